// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial byte receiver: state encoding, line idle level
// and the bit-counter width helper.
package serial_rx_pkg;

  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DATA     = 3'd1,
    ST_PARITY   = 3'd2,
    ST_STOP     = 3'd3,
    ST_DONE     = 3'd4,
    ST_PERR     = 3'd5,
    ST_ERR_WAIT = 3'd6
  } state_e;

  // Width needed to hold the values 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_parity_acc.sv
// Running parity of the bits sampled in a frame: a single toggle flop,
// cleared when a frame starts.
module serial_parity_acc (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic toggle_i,
  output logic acc_o
);

  logic acc_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      acc_q <= 1'b0;
    end else if (toggle_i) begin
      acc_q <= ~acc_q;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/serial_byte_rx.sv
// Serial frame receiver, one bit per clock: start, DATA_BITS data LSB-first, stop.
// Define SERIAL_BYTE_RX_PARITY_EN to expect and check an odd-parity bit before the stop bit.
module serial_byte_rx
  import serial_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in,
  output logic [DATA_BITS-1:0] out_byte,
  output logic                 done,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int unsigned CNT_W = cnt_width(DATA_BITS);

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] out_byte_q, out_byte_d;
  logic [DATA_BITS:0]   shift_ext;
  logic                 parity_ok;

`ifdef SERIAL_BYTE_RX_PARITY_EN
  logic frame_start;
  logic acc_toggle;
  logic acc;

  assign frame_start = (state_q inside {ST_IDLE, ST_DONE, ST_PERR}) && (in != IDLE_LEVEL);
  assign acc_toggle  = (state_q inside {ST_DATA, ST_PARITY}) && in;

  serial_parity_acc u_parity_acc (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (frame_start),
    .toggle_i (acc_toggle),
    .acc_o    (acc)
  );

  // Odd parity: data plus parity bit carry an odd number of ones.
  assign parity_ok = acc;
`else
  assign parity_ok = 1'b1;
`endif

  // Right shift with the new bit entering at the MSB; also valid for DATA_BITS == 1.
  assign shift_ext = {in, shift_q};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      out_byte_q <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      out_byte_q <= out_byte_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    out_byte_d = out_byte_q;
    unique case (state_q)
      ST_IDLE, ST_DONE
`ifdef SERIAL_BYTE_RX_PARITY_EN
      , ST_PERR
`endif
      : begin
        if (in != IDLE_LEVEL) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        shift_d   = shift_ext[DATA_BITS:1];
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
`ifdef SERIAL_BYTE_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef SERIAL_BYTE_RX_PARITY_EN
      ST_PARITY: state_d = ST_STOP;
`endif
      ST_STOP: begin
        if (in != IDLE_LEVEL) begin
          state_d = ST_ERR_WAIT;
        end else if (parity_ok) begin
          state_d    = ST_DONE;
          out_byte_d = shift_q;
        end else begin
          state_d = ST_PERR;
        end
      end
      ST_ERR_WAIT: begin
        if (in == IDLE_LEVEL) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_byte  = out_byte_q;
  assign done      = (state_q == ST_DONE);
  assign frame_err = (state_q == ST_ERR_WAIT);
`ifdef SERIAL_BYTE_RX_PARITY_EN
  assign parity_err = (state_q == ST_PERR);
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_byte_rx.sv
// Directed bench for serial_byte_rx; adapts frame format to SERIAL_BYTE_RX_PARITY_EN.
module tb_serial_byte_rx;

  localparam int unsigned DB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in;
  logic [DB-1:0] out_byte;
  logic          done;
  logic          parity_err;
  logic          frame_err;

  int checks = 0;
  int errors = 0;

  serial_byte_rx #(.DATA_BITS(DB)) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .out_byte   (out_byte),
    .done       (done),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one line bit, let it be sampled, then look at the registered outputs.
  task automatic step(input logic b);
    in = b;
    @(posedge clk);
    #1;
    check("exclusive", 32'($countones({done, parity_err, frame_err}) <= 1), 32'd1);
  endtask

  function automatic logic odd_par(input logic [DB-1:0] d);
    return ~(^d);
  endfunction

  // Data bits, optional parity bit, stop bit (start bit already sent).
  task automatic send_body(input logic [DB-1:0] d, input logic par, input logic stp);
    for (int i = 0; i < int'(DB); i++) step(d[i]);
`ifdef SERIAL_BYTE_RX_PARITY_EN
    step(par);
`endif
    check("no_early_done", 32'(done), 32'd0);
    step(stp);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic par, input logic stp);
    step(1'b0);
    send_body(d, par, stp);
  endtask

  initial begin
    reset = 1'b1;
    in    = 1'b1;
    step(1'b1);
    step(1'b1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_perr", 32'(parity_err), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_byte", 32'(out_byte), 32'h00);
    reset = 1'b0;
    step(1'b1);
    step(1'b1);
    check("idle_done", 32'(done), 32'd0);

    // Good frame 0xA5
    send_frame(8'hA5, 1'b1, 1'b1);
    check("t1_done", 32'(done), 32'd1);
    check("t1_byte", 32'(out_byte), 32'hA5);
    check("t1_perr", 32'(parity_err), 32'd0);
    step(1'b1);
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_byte_held", 32'(out_byte), 32'hA5);

`ifdef SERIAL_BYTE_RX_PARITY_EN
    // Bad parity on 0x5A: byte must not be delivered
    send_frame(8'h5A, ~odd_par(8'h5A), 1'b1);
    check("t2_perr", 32'(parity_err), 32'd1);
    check("t2_done", 32'(done), 32'd0);
    check("t2_byte_held", 32'(out_byte), 32'hA5);
    step(1'b1);
    check("t2_perr_pulse", 32'(parity_err), 32'd0);
`endif

    // Bad stop bit, line held low, then recovery
    send_frame(8'h3C, odd_par(8'h3C), 1'b0);
    check("t3_ferr", 32'(frame_err), 32'd1);
    check("t3_done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      check("t3_ferr_hold", 32'(frame_err), 32'd1);
    end
    check("t3_byte_held", 32'(out_byte), 32'hA5);
    step(1'b1);
    check("t3_ferr_clr", 32'(frame_err), 32'd0);
    step(1'b1);
    send_frame(8'h3C, odd_par(8'h3C), 1'b1);
    check("t3_good_done", 32'(done), 32'd1);
    check("t3_good_byte", 32'(out_byte), 32'h3C);
    step(1'b1);

    // Back-to-back frames: second start bit sampled in the first done cycle
    send_frame(8'h01, odd_par(8'h01), 1'b1);
    check("t4_done1", 32'(done), 32'd1);
    check("t4_byte1", 32'(out_byte), 32'h01);
    step(1'b0);
    check("t4_done1_pulse", 32'(done), 32'd0);
    send_body(8'hFF, odd_par(8'hFF), 1'b1);
    check("t4_done2", 32'(done), 32'd1);
    check("t4_byte2", 32'(out_byte), 32'hFF);
    step(1'b1);
    check("t4_done2_pulse", 32'(done), 32'd0);

    // Reset at the 4th data bit of 0x77
    step(1'b0);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    reset = 1'b1;
    step(1'b0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_perr", 32'(parity_err), 32'd0);
    check("t5_ferr", 32'(frame_err), 32'd0);
    check("t5_byte", 32'(out_byte), 32'h00);
    reset = 1'b0;
    step(1'b1);
    step(1'b1);
    check("t5_no_done", 32'(done), 32'd0);
    send_frame(8'h12, odd_par(8'h12), 1'b1);
    check("t5_done_12", 32'(done), 32'd1);
    check("t5_byte_12", 32'(out_byte), 32'h12);
    step(1'b1);

    // 0x5A good frame; in the default build this is the no-parity format
    send_frame(8'h5A, odd_par(8'h5A), 1'b1);
    check("t6_done", 32'(done), 32'd1);
    check("t6_byte", 32'(out_byte), 32'h5A);
    check("t6_perr", 32'(parity_err), 32'd0);
    step(1'b1);
    check("t6_done_pulse", 32'(done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
